// File: rtl/wb_host_arbiter.sv
// Round-robin two-master Wishbone arbiter: mgmt SoC bus (m0) and LA debug master (m1).
// Optional bus watchdog is compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_host_arbiter #(
    parameter int unsigned      AW             = 32,
    parameter int unsigned      DW             = 32,
    parameter int unsigned      TIMEOUT_CYCLES = 255,
    parameter logic [DW-1:0]    TO_DATA        = 32'hDEADBEEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    input  logic          la_req_i,
    input  logic          la_we_i,
    input  logic [AW-1:0] la_adr_i,
    input  logic [DW-1:0] la_dat_i,
    output logic [DW-1:0] la_dat_o,
    output logic          la_done_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o,
    output logic          timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          last, last_nxt;   // master served last: 0 = m0, 1 = m1
    logic          req0, req1;
    logic          to_hit;
    logic          done;

    logic          la_req_q;
    logic          la_rise;
    logic          la_pend;
    logic          la_we;
    logic [AW-1:0] la_adr;
    logic [DW-1:0] la_dat;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = la_pend;
    assign la_rise = la_req_i & ~la_req_q;
    assign done    = s_ack_i | to_hit;
    assign gnt_o   = {state == GNT1, state == GNT0};

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] cnt;

    // A real ack in the same cycle takes priority over the watchdog.
    assign to_hit = ((state == GNT1) || ((state == GNT0) && req0)) && !s_ack_i
                    && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (state == IDLE)
                cnt <= '0;
            else if (!s_ack_i)
                cnt <= cnt + CW'(1);
            if (to_hit)
                timeout_o <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign to_hit     = 1'b0;
    assign timeout_o  = 1'b0;
    assign unused_cfg = ^{TIMEOUT_CYCLES, TO_DATA};
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m0_ack_o  = 1'b0;
        m0_dat_o  = s_dat_i;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last))
                    state_nxt = GNT0;
                else if (req1)
                    state_nxt = GNT1;
            end
            GNT0: begin
                s_cyc_o  = req0;
                s_stb_o  = req0;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = done;
                if (to_hit)
                    m0_dat_o = TO_DATA;
                if (!req0) begin
                    state_nxt = IDLE;
                end else if (done) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            GNT1: begin
                s_cyc_o = 1'b1;
                s_stb_o = 1'b1;
                s_we_o  = la_we;
                s_sel_o = 4'hF;
                s_adr_o = la_adr;
                s_dat_o = la_dat;
                if (done) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // LA edge capture, pending flag and registered read-back.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            la_req_q  <= 1'b0;
            la_pend   <= 1'b0;
            la_we     <= 1'b0;
            la_adr    <= '0;
            la_dat    <= '0;
            la_dat_o  <= '0;
            la_done_o <= 1'b0;
        end else begin
            la_req_q  <= la_req_i;
            la_done_o <= (state == GNT1) && done;
            if ((state == GNT1) && done) begin
                la_pend <= 1'b0;
                if (to_hit)
                    la_dat_o <= TO_DATA;
                else if (!la_we)
                    la_dat_o <= s_dat_i;
            end else if (la_rise && !la_pend) begin
                la_pend <= 1'b1;
                la_we   <= la_we_i;
                la_adr  <= la_adr_i;
                la_dat  <= la_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_host_arbiter.sv
// Directed self-checking bench for wb_host_arbiter; the watchdog scenario
// runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_host_arbiter;

    logic        clk;
    logic        wb_rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o;
    logic        la_req_i, la_we_i;
    logic [31:0] la_adr_i, la_dat_i, la_dat_o;
    logic        la_done_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_host_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i (clk),       .wb_rst_i (wb_rst_i),
        .m0_cyc_i (m0_cyc_i),  .m0_stb_i (m0_stb_i),  .m0_we_i (m0_we_i),
        .m0_sel_i (m0_sel_i),  .m0_adr_i (m0_adr_i),  .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o),  .m0_ack_o (m0_ack_o),
        .la_req_i (la_req_i),  .la_we_i  (la_we_i),   .la_adr_i (la_adr_i),
        .la_dat_i (la_dat_i),  .la_dat_o (la_dat_o),  .la_done_o(la_done_o),
        .s_cyc_o  (s_cyc_o),   .s_stb_o  (s_stb_o),   .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),   .s_adr_o  (s_adr_o),   .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),   .s_ack_i  (s_ack_i),
        .gnt_o    (gnt_o),     .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        wb_rst_i = 1'b1;
        step;
        step;
        n_cmp++; if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL rst_gnt got=%b want=00", gnt_o); end
        n_cmp++; if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 7'b0) begin n_bad++; $display("FAIL rst_sctl got=%b want=0", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}); end
        n_cmp++; if ({s_adr_o, s_dat_o} !== 64'h0) begin n_bad++; $display("FAIL rst_sbus got=%h want=0", {s_adr_o, s_dat_o}); end
        n_cmp++; if ({m0_ack_o, la_done_o, timeout_o} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got=%b want=000", {m0_ack_o, la_done_o, timeout_o}); end
        n_cmp++; if (la_dat_o !== 32'h0) begin n_bad++; $display("FAIL rst_la_dat got=%h want=0", la_dat_o); end
        wb_rst_i = 1'b0;
        step;
    endtask

    task automatic test_m0_read;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_sel_i = 4'hF;
        m0_adr_i = 32'h3000_0004; m0_dat_i = 32'h0;
        #1;
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL t1_cyc_before_grant got=%b want=0", s_cyc_o); end
        step;
        n_cmp++; if (s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL t1_cyc_grant got=%b want=1", s_cyc_o); end
        n_cmp++; if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL t1_gnt got=%b want=01", gnt_o); end
        n_cmp++; if (s_adr_o !== 32'h3000_0004) begin n_bad++; $display("FAIL t1_adr got=%h want=30000004", s_adr_o); end
        n_cmp++; if (s_we_o !== 1'b0) begin n_bad++; $display("FAIL t1_we got=%b want=0", s_we_o); end
        step;
        n_cmp++; if (m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL t1_no_early_ack got=%b want=0", m0_ack_o); end
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
        #1;
        n_cmp++; if (m0_ack_o !== 1'b1) begin n_bad++; $display("FAIL t1_ack got=%b want=1", m0_ack_o); end
        n_cmp++; if (m0_dat_o !== 32'h1234_5678) begin n_bad++; $display("FAIL t1_rdata got=%h want=12345678", m0_dat_o); end
        step;
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        n_cmp++; if (m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL t1_ack_one_cycle got=%b want=0", m0_ack_o); end
        n_cmp++; if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL t1_idle got=%b want=00", gnt_o); end
    endtask

    task automatic test_la_write;
        la_we_i = 1'b1; la_adr_i = 32'h10; la_dat_i = 32'hA5A5_A5A5; la_req_i = 1'b1;
        step;
        n_cmp++; if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL t2_pend_cycle got=%b want=00", gnt_o); end
        step;
        // Change the live LA inputs: the slave must still see the latched fields.
        la_req_i = 1'b0; la_dat_i = 32'h0; la_adr_i = 32'hFFF; la_we_i = 1'b0;
        #1;
        n_cmp++; if (gnt_o !== 2'b10) begin n_bad++; $display("FAIL t2_gnt got=%b want=10", gnt_o); end
        n_cmp++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b111) begin n_bad++; $display("FAIL t2_ctl got=%b want=111", {s_cyc_o, s_stb_o, s_we_o}); end
        n_cmp++; if (s_sel_o !== 4'hF) begin n_bad++; $display("FAIL t2_sel got=%h want=f", s_sel_o); end
        n_cmp++; if (s_adr_o !== 32'h10) begin n_bad++; $display("FAIL t2_adr got=%h want=10", s_adr_o); end
        n_cmp++; if (s_dat_o !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL t2_wdata got=%h want=a5a5a5a5", s_dat_o); end
        s_ack_i = 1'b1; s_dat_i = 32'h9999_9999;
        #1;
        n_cmp++; if (la_done_o !== 1'b0) begin n_bad++; $display("FAIL t2_done_early got=%b want=0", la_done_o); end
        step;
        s_ack_i = 1'b0;
        n_cmp++; if (la_done_o !== 1'b1) begin n_bad++; $display("FAIL t2_done got=%b want=1", la_done_o); end
        n_cmp++; if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL t2_idle got=%b want=00", gnt_o); end
        step;
        n_cmp++; if (la_done_o !== 1'b0) begin n_bad++; $display("FAIL t2_done_pulse got=%b want=0", la_done_o); end
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL t2_no_regrant got=%b want=0", s_cyc_o); end
        n_cmp++; if (la_dat_o !== 32'h0) begin n_bad++; $display("FAIL t2_la_dat_held got=%h want=0", la_dat_o); end
    endtask

    task automatic test_arbitration;
        wb_rst_i = 1'b1;
        step;
        wb_rst_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h100;
        la_req_i = 1'b1; la_we_i = 1'b0; la_adr_i = 32'h200;
        step;
        n_cmp++; if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL t3_first_m0 got=%b want=01", gnt_o); end
        s_ack_i = 1'b1; s_dat_i = 32'h11;
        step;
        s_ack_i = 1'b0; la_req_i = 1'b0;
        n_cmp++; if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL t3_idle_gap got=%b want=00", gnt_o); end
        step;
        n_cmp++; if (gnt_o !== 2'b10) begin n_bad++; $display("FAIL t3_then_m1 got=%b want=10", gnt_o); end
        n_cmp++; if (s_adr_o !== 32'h200) begin n_bad++; $display("FAIL t3_m1_adr got=%h want=200", s_adr_o); end
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
        step;
        s_ack_i = 1'b0; la_req_i = 1'b1; la_adr_i = 32'h300;
        n_cmp++; if (la_done_o !== 1'b1) begin n_bad++; $display("FAIL t3_la_done got=%b want=1", la_done_o); end
        step;
        n_cmp++; if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL t3_m0_again got=%b want=01", gnt_o); end
        n_cmp++; if (la_dat_o !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL t3_la_rdata got=%h want=cafef00d", la_dat_o); end
        s_ack_i = 1'b1;
        step;
        s_ack_i = 1'b0; la_req_i = 1'b0;
        n_cmp++; if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL t3_idle_gap2 got=%b want=00", gnt_o); end
        step;
        n_cmp++; if (gnt_o !== 2'b10) begin n_bad++; $display("FAIL t3_m1_again got=%b want=10", gnt_o); end
        n_cmp++; if (s_adr_o !== 32'h300) begin n_bad++; $display("FAIL t3_m1_adr2 got=%h want=300", s_adr_o); end
        s_ack_i = 1'b1; s_dat_i = 32'h0;
        step;
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        n_cmp++; if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL t3_end_idle got=%b want=00", gnt_o); end
    endtask

    task automatic test_abort;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h400;
        la_req_i = 1'b1; la_we_i = 1'b1; la_adr_i = 32'h500; la_dat_i = 32'h77;
        step;
        n_cmp++; if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL t4_gnt0 got=%b want=01", gnt_o); end
        m0_cyc_i = 1'b0;
        #1;
        n_cmp++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin n_bad++; $display("FAIL t4_cyc_drop got=%b want=00", {s_cyc_o, s_stb_o}); end
        n_cmp++; if (m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL t4_no_ack got=%b want=0", m0_ack_o); end
        step;
        n_cmp++; if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL t4_idle got=%b want=00", gnt_o); end
        step;
        la_req_i = 1'b0; m0_stb_i = 1'b0;
        n_cmp++; if (gnt_o !== 2'b10) begin n_bad++; $display("FAIL t4_la_next got=%b want=10", gnt_o); end
        n_cmp++; if (s_adr_o !== 32'h500) begin n_bad++; $display("FAIL t4_la_adr got=%h want=500", s_adr_o); end
        s_ack_i = 1'b1;
        step;
        s_ack_i = 1'b0;
        n_cmp++; if (la_done_o !== 1'b1) begin n_bad++; $display("FAIL t4_la_done got=%b want=1", la_done_o); end
        step;
    endtask

    task automatic test_reset_mid;
        la_req_i = 1'b1; la_we_i = 1'b1; la_adr_i = 32'h44; la_dat_i = 32'h5555;
        step;
        la_req_i = 1'b0;
        step;
        n_cmp++; if (gnt_o !== 2'b10) begin n_bad++; $display("FAIL t5_gnt1 got=%b want=10", gnt_o); end
        wb_rst_i = 1'b1;
        step;
        n_cmp++; if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL t5_gnt got=%b want=00", gnt_o); end
        n_cmp++; if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 7'b0) begin n_bad++; $display("FAIL t5_sctl got=%b want=0", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}); end
        n_cmp++; if ({s_adr_o, s_dat_o} !== 64'h0) begin n_bad++; $display("FAIL t5_sbus got=%h want=0", {s_adr_o, s_dat_o}); end
        n_cmp++; if ({m0_ack_o, la_done_o} !== 2'b00) begin n_bad++; $display("FAIL t5_flags got=%b want=00", {m0_ack_o, la_done_o}); end
        wb_rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            n_cmp++; if ({gnt_o, la_done_o} !== 3'b000) begin n_bad++; $display("FAIL t5_after_rst%0d got=%b want=000", i, {gnt_o, la_done_o}); end
        end
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout;
        s_dat_i = 32'h55; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h600;
        for (int k = 1; k <= 8; k++) begin
            step;
            if (k < 8) begin
                n_cmp++; if (m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL t6_ack_c%0d got=%b want=0", k, m0_ack_o); end
            end else begin
                n_cmp++; if (m0_ack_o !== 1'b1) begin n_bad++; $display("FAIL t6_ack_c8 got=%b want=1", m0_ack_o); end
                n_cmp++; if (m0_dat_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL t6_to_data got=%h want=deadbeef", m0_dat_o); end
            end
        end
        step;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        n_cmp++; if (timeout_o !== 1'b1) begin n_bad++; $display("FAIL t6_flag got=%b want=1", timeout_o); end
        n_cmp++; if ({gnt_o, s_cyc_o} !== 3'b000) begin n_bad++; $display("FAIL t6_released got=%b want=000", {gnt_o, s_cyc_o}); end
        step;
        step;
        n_cmp++; if (timeout_o !== 1'b1) begin n_bad++; $display("FAIL t6_sticky got=%b want=1", timeout_o); end
    endtask
`endif

    initial begin
        wb_rst_i = 1'b1;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_sel_i = 4'h0;
        m0_adr_i = 32'h0; m0_dat_i = 32'h0;
        la_req_i = 1'b0; la_we_i = 1'b0; la_adr_i = 32'h0; la_dat_i = 32'h0;
        s_dat_i = 32'h0; s_ack_i = 1'b0;
        test_reset;
        test_m0_read;
        test_la_write;
        test_arbitration;
        test_abort;
        test_reset_mid;
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
